reg_file: RTL and testbench
===========================

# reg_file

Multi-read, single-write register file for the MIPS multi-cycle datapath. It holds the architectural general-purpose registers and serves two combinational read ports, A (rs) and B (rt), that feed the datapath's operand registers. Each register is updated through a one-hot write-enable demultiplexer that steers a single write port into exactly one register per cycle. Register 0 is hard-wired to zero.

## Interface
Parameters:
- NUM_REGS, 32: number of architectural registers; must be a power of two, at least 2.
- WIDTH, 32: data width of every register, in bits.
- ADDR_WIDTH, $clog2(NUM_REGS): derived local parameter; do not override.

Ports:
- clk  input  1  single clock for the block; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- we  input  1  write enable; sampled on the rising clk edge.
- wr_addr  input  ADDR_WIDTH  destination register index.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  ADDR_WIDTH  read port A index (rs).
- rd_addr_b  input  ADDR_WIDTH  read port B index (rt).
- rd_data_a  output  WIDTH  contents of register rd_addr_a.
- rd_data_b  output  WIDTH  contents of register rd_addr_b.

## Operation
- **Storage:** NUM_REGS registers of WIDTH bits. Register 0 is never stored; it is a constant zero.
- **Reset:**
  - rst high clears registers 1..NUM_REGS-1 to 0 immediately, without waiting for clk.
  - Registers stay cleared for as long as rst is high.
  - Writes are ignored while rst is high.
- **Write decode:**
  - The demux sub-module turns {we, wr_addr} into a NUM_REGS-bit one-hot enable vector.
  - When we is low, the vector is all zeros.
  - Bit 0 of the vector is forced to 0.
- **Write:** on the rising clk edge, with rst low and we high, register[wr_addr] <= wr_data, for wr_addr != 0.
- **Write to register 0:** silently discarded; no register changes.
- **Read:**
  - Both ports are purely combinational: rd_data_x = (rd_addr_x == 0) ? 0 : register[rd_addr_x].
  - Ports A and B are independent and may address the same register.
- **No write-to-read bypass:**
  - A read of wr_addr in the same cycle as the write returns the old value.
  - The new value appears after the rising edge.
- **Output reset values:** during and after reset, rd_data_a = rd_data_b = 0 for every address.
- **Arithmetic:** none. The data path has no width conversion; wr_data is stored bit-exact.

## Timing
- **Write latency:** 1 clock. Data presented in cycle N is visible on the read ports in cycle N+1.
- **Read latency:** 0 clocks. Output follows rd_addr_x and register contents within the same cycle.
- **Reset assertion:** outputs go to 0 asynchronously, with no clock edge required.
- **Reset deassertion:** the first write can take effect on the first rising edge after rst is low.
- **Reset mid-operation:** a write whose edge coincides with rst high is lost. Registers read 0 after reset regardless of earlier writes.
- **Simultaneous events:**
  - A write on port W while ports A and B read any addresses, including the same address, is legal.
  - The reads return pre-edge contents.
- **Boundaries:**
  - wr_addr = NUM_REGS-1 and rd_addr = NUM_REGS-1 must work.
  - Addresses cannot exceed NUM_REGS-1 because NUM_REGS is a power of two.

## Structure
- **Shared package (mips_pkg):**
  - NUM_REGS, WIDTH, REG_ZERO (index 0) and REG_RA (index 31) constants.
  - reg_addr_t typedef (logic[ADDR_WIDTH-1:0]).
  - word_t typedef (logic[WIDTH-1:0]).
- **Sub-module demux:** parameterized by NUM_OUTPUTS and SEL_WIDTH.
  - Inputs: en and sel.
  - Output: NUM_OUTPUTS-bit one-hot vector.
  - reg_file instantiates it for write enables.
  - The datapath can reuse it wherever a select must be turned into per-target enables.
- **Storage:**
  - One always_ff with asynchronous rst for the register array, indexed 1..NUM_REGS-1.
  - Read muxing in always_comb.

## Test plan
- **Reset:** assert rst with registers preloaded (r5 = 0x12345678), no clock edge. Required: rd_data_a at address 5 reads 0x00000000 immediately; all 32 addresses read 0 on both ports.
- **Basic write:** write 0xDEADBEEF to r5 with we = 1. Required: rd_data_a and rd_data_b at address 5 read 0xDEADBEEF starting the cycle after the edge; r4 and r6 still read 0.
- **Register 0:** write 0xFFFFFFFF to r0. Required: both ports at address 0 read 0x00000000; no other register changes.
- **Same-cycle collision:** r7 = 0x1; write 0x2 to r7 while rd_addr_a = rd_addr_b = 7. Required: both ports read 0x1 before the edge and 0x2 after it.
- **Write-enable gating:** we = 0 with wr_addr = 9 and wr_data = 0xA5A5A5A5 for 3 cycles. Required: r9 stays 0. Then write 0xCAFEF00D to r31. Required: r31 reads 0xCAFEF00D; demux vector is one-hot at bit 31.
- **Reset mid-operation:** fill r1..r31 with their own index values, then pulse rst high between clock edges while we = 1 targets r3. Required: all registers read 0 after rst drops; the write to r3 is lost; a subsequent write of 0x55 to r3 lands one cycle later.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS multi-cycle datapath.
package mips_pkg;

  localparam int NUM_REGS   = 32;
  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  // Architectural register indices with a fixed role.
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]      word_t;

endpackage : mips_pkg

// File: rtl/reg_file_demux.sv
// Enable demultiplexer: steers a single enable onto one of NUM_OUTPUTS lines
// selected by sel. All outputs are low when en is low.
module demux #(
  parameter int NUM_OUTPUTS = 32,
  parameter int SEL_WIDTH   = $clog2(NUM_OUTPUTS)
) (
  input  logic                   en,
  input  logic [SEL_WIDTH-1:0]   sel,
  output logic [NUM_OUTPUTS-1:0] onehot
);

  // Decode sel into a one-hot vector, gated by en.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this purely
    // combinational; omitting it would infer a latch on every output bit.
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule : demux

// File: rtl/reg_file.sv
// Two-read, one-write general-purpose register file. Register 0 is a
// constant zero and has no storage; writes to it are dropped. Reads are
// combinational with no write bypass: a same-cycle read sees the old value.
module reg_file #(
  parameter  int NUM_REGS   = mips_pkg::NUM_REGS,
  parameter  int WIDTH      = mips_pkg::WIDTH,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_a,
  output logic [WIDTH-1:0]      rd_data_b
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(mips_pkg::REG_ZERO);

  // Storage for registers 1..NUM_REGS-1 only; register 0 is never stored.
  logic [WIDTH-1:0]    regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] wr_en;
  logic                wr_req;

  // A write to register 0 never raises a demux output, so bit 0 of the
  // enable vector is always low.
  assign wr_req = we && (wr_addr != ZERO_ADDR);

  demux #(
    .NUM_OUTPUTS (NUM_REGS),
    .SEL_WIDTH   (ADDR_WIDTH)
  ) u_wr_demux (
    .en     (wr_req),
    .sel    (wr_addr),
    .onehot (wr_en)
  );

  // Bit 0 has no register behind it; it is tied off here on purpose.
  logic unused_wr_en0;
  assign unused_wr_en0 = wr_en[0];

  // Register array: async clear on rst, otherwise load the enabled register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is ordinary flops that must read zero after reset,
      // so every entry is cleared; a RAM macro would not be reset like this.
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment, so a read in the same cycle still sees
      // the pre-edge contents (no bypass) and flops update together.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Read port A: constant zero for register 0, stored value otherwise.
  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != ZERO_ADDR) begin
      rd_data_a = regs[rd_addr_a];
    end
  end

  // Read port B: independent of port A, same rule.
  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != ZERO_ADDR) begin
      rd_data_b = regs[rd_addr_b];
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed scenarios followed by random traffic.
// The stimulus process pushes expected read values into a scoreboard queue
// from an array model; a monitor pops and compares on each falling edge.
module tb_reg_file;
  import mips_pkg::*;

  logic      clk;
  logic      rst;
  logic      we;
  reg_addr_t wr_addr;
  word_t     wr_data;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  word_t     rd_data_a;
  word_t     rd_data_b;

  reg_file #(
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string     name;
    reg_addr_t ra;
    word_t     ea;
    reg_addr_t rb;
    word_t     eb;
  } exp_t;

  exp_t  sb[$];
  word_t model [NUM_REGS];
  int    tests_run = 0;
  int    tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge. The model is a
  // plain array: reset clears it, a write becomes visible on the next cycle.
  task automatic step(input bit r, input bit w, input reg_addr_t wa, input word_t wd,
                      input reg_addr_t ra, input reg_addr_t rb, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; we = w; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    if (r) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end
    e.name = nm; e.ra = ra; e.ea = model[ra]; e.rb = rb; e.eb = model[rb];
    sb.push_back(e);
    if (!r && w && wa != '0) model[wa] = wd;
  endtask

  // Monitor: compares both read ports against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("%s_a[%0d]", e.name, e.ra), rd_data_a, e.ea);
        check($sformatf("%s_b[%0d]", e.name, e.rb), rd_data_b, e.eb);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit        r, w;
    reg_addr_t wa, ra, rb;
    word_t     wd;

    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // Reset state.
    step(1, 0, 0, 0, 0, reg_addr_t'(REG_RA), "por");
    step(0, 0, 0, 0, 5, 5, "por_release");

    // Preload r5, then assert reset without an edge: r5 must read 0 at once.
    step(0, 1, 5, 32'h1234_5678, 5, 4, "preload");
    step(0, 0, 0, 0, 5, 5, "preload_rd");
    step(1, 1, 5, 32'hFFFF_0000, 5, 5, "rst_async");
    for (int i = 0; i < NUM_REGS; i++)
      step(1, 1, reg_addr_t'(i), $urandom, reg_addr_t'(i), reg_addr_t'(i), "rst_all");

    // Basic write, neighbours untouched.
    step(0, 1, 5, 32'hDEAD_BEEF, 5, 5, "wr5_same");
    step(0, 0, 0, 0, 5, 5, "wr5");
    step(0, 0, 0, 0, 4, 6, "wr5_nb");

    // Register 0 discards writes.
    step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, "r0_wr");
    step(0, 0, 0, 0, 0, 0, "r0");
    step(0, 0, 0, 0, 5, 4, "r0_others");

    // Same-cycle collision on r7.
    step(0, 1, 7, 32'h1, 7, 7, "r7_init");
    step(0, 1, 7, 32'h2, 7, 7, "r7_old");
    step(0, 0, 0, 0, 7, 7, "r7_new");

    // Write-enable gating, then a write to the top register.
    for (int i = 0; i < 3; i++) step(0, 0, 9, 32'hA5A5_A5A5, 9, 9, "we_gate");
    step(0, 0, 0, 0, 9, 9, "we_gate_after");
    step(0, 1, reg_addr_t'(REG_RA), 32'hCAFE_F00D, 31, 9, "r31_wr");
    #1;
    check("demux_onehot", dut.wr_en, 32'h8000_0000);
    step(0, 0, 0, 0, 31, 31, "r31");

    // Fill r1..r31 with their index, then reset across an edge with a write to r3.
    for (int i = 1; i < NUM_REGS; i++)
      step(0, 1, reg_addr_t'(i), word_t'(i), reg_addr_t'(i - 1), 3, "fill");
    step(0, 0, 0, 0, 31, 30, "fill_rd");
    step(1, 1, 3, 32'h0000_0033, 3, 31, "mid_rst");
    step(0, 0, 0, 0, 3, 3, "mid_rst_lost");
    for (int i = 0; i < NUM_REGS; i++)
      step(0, 0, 0, 0, reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i), "post_rst");
    step(0, 1, 3, 32'h55, 3, 3, "r3_wr");
    step(0, 0, 0, 0, 3, 3, "r3");

    // Random traffic with occasional reset and deliberate address collisions.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      w  = $urandom_range(0, 1) != 0;
      wa = reg_addr_t'($urandom);
      wd = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? wa : reg_addr_t'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : reg_addr_t'($urandom);
      step(r, w, wa, wd, ra, rb, "rand");
    end

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    #1;
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_reg_file
